// File: rtl/lut_pkg.sv
// Shared definitions for the LUT table writer: state encoding, default sizes
// and the number of load beats needed to fill every neuron table.
package lut_pkg;

    localparam int DEF_NEURONS = 8;
    localparam int DEF_IN_BITS = 6;
    localparam int DEF_LOAD_W  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    function automatic int beats_per_load(input int neurons, input int in_bits, input int load_w);
        return (neurons * (1 << in_bits)) / load_w;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// One neuron's 2**IN_BITS x 1 truth table: bit-masked write port, registered lookup read.
// With LUT_TABLE_READBACK_EN a second registered read port serves debug readback.
module lut_table_ram #(
    parameter int IN_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [(1<<IN_BITS)-1:0]  wr_mask,
    input  logic [(1<<IN_BITS)-1:0]  wr_data,
    input  logic                     rd_en,
    input  logic [IN_BITS-1:0]       rd_addr,
    output logic                     rd_data
`ifdef LUT_TABLE_READBACK_EN
    ,
    input  logic                     rb_en,
    input  logic [IN_BITS-1:0]       rb_addr,
    output logic                     rb_data
`endif
);

    logic [(1<<IN_BITS)-1:0] mem;

    // NOTE: table storage has no reset so it maps onto plain RAM cells; only the read registers are reset.
    always_ff @(posedge clk) begin
        if (|wr_mask) begin
            mem <= (mem & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 1'b0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef LUT_TABLE_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_data <= 1'b0;
        end else if (rb_en) begin
            rb_data <= mem[rb_addr];
        end
    end
`endif

endmodule

// File: rtl/lut_table_writer.sv
// Loads NEURONS 1-bit LUT truth tables from a beat stream, then serves parallel lookups.
// Optional debug readback port enabled by macro LUT_TABLE_READBACK_EN.
module lut_table_writer
    import lut_pkg::*;
#(
    parameter int NEURONS = DEF_NEURONS,
    parameter int IN_BITS = DEF_IN_BITS,
    parameter int LOAD_W  = DEF_LOAD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [LOAD_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       in_valid,
    input  logic [NEURONS*IN_BITS-1:0] in_addr,
    output logic                       out_valid,
    output logic [NEURONS-1:0]         out_bits
`ifdef LUT_TABLE_READBACK_EN
    ,
    input  logic                       rb_req,
    input  logic [$clog2(NEURONS)-1:0] rb_sel,
    input  logic [IN_BITS-1:0]         rb_addr,
    output logic                       rb_data
`endif
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam int TOTAL = NEURONS * DEPTH;
    localparam int BEATS = beats_per_load(NEURONS, IN_BITS, LOAD_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t           state;
    logic [CNT_W-1:0] beat;
    logic             load_fire;
    logic             last_beat;
    logic             lookup;
    logic [TOTAL-1:0] wr_mask;
    logic [TOTAL-1:0] wr_data;

    assign ld_ready  = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD);
    assign done      = (state == ST_RUN);
    assign err       = (state == ST_ERR);
    assign load_fire = ld_valid && ld_ready;
    assign last_beat = (beat == CNT_W'(BEATS - 1));
    assign lookup    = in_valid && (state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // start is deliberately ignored here so a stray pulse cannot restart a load
                    if (load_fire) begin
                        if (last_beat) begin
                            state <= ld_last ? ST_RUN : ST_ERR;
                        end else if (ld_last) begin
                            state <= ST_ERR;
                        end else begin
                            beat <= beat + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state <= ST_LOAD;
                        beat  <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= lookup;
        end
    end

    // Stream bit k lands in neuron k/DEPTH, entry k%DEPTH; a beat owns bits [beat*LOAD_W +: LOAD_W].
    for (genvar k = 0; k < TOTAL; k++) begin : g_bit
        assign wr_mask[k] = load_fire && (beat == CNT_W'(k / LOAD_W));
        assign wr_data[k] = ld_data[k % LOAD_W];
    end

`ifdef LUT_TABLE_READBACK_EN
    logic [NEURONS-1:0]         rb_bits;
    logic [$clog2(NEURONS)-1:0] rb_sel_q;
    logic                       rb_fire;

    assign rb_fire = rb_req && (state != ST_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_sel_q <= '0;
        end else if (rb_fire) begin
            rb_sel_q <= rb_sel;
        end
    end

    assign rb_data = (state == ST_LOAD) ? 1'b0 : rb_bits[rb_sel_q];
`endif

    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        lut_table_ram #(
            .IN_BITS (IN_BITS)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_mask (wr_mask[n*DEPTH +: DEPTH]),
            .wr_data (wr_data[n*DEPTH +: DEPTH]),
            .rd_en   (lookup),
            .rd_addr (in_addr[n*IN_BITS +: IN_BITS]),
            .rd_data (out_bits[n])
`ifdef LUT_TABLE_READBACK_EN
            ,
            .rb_en   (rb_fire),
            .rb_addr (rb_addr),
            .rb_data (rb_bits[n])
`endif
        );
    end

endmodule

// File: doc/lut_table_writer.md
LUT_TABLE_WRITER -- requirements
Module: lut_table_writer

Interface
REQ-001 Parameter NEURONS, default 8, is the number of 1-bit LUT neurons held.
REQ-002 Parameter IN_BITS, default 6, is the address width per neuron; table depth is 2**IN_BITS (64).
REQ-003 Parameter LOAD_W, default 8, is the truth-table bits per load beat; NEURONS*2**IN_BITS SHALL be a multiple of LOAD_W.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a table load.
REQ-007 ld_valid / ld_ready  input / output  1 / 1  load-beat handshake.
REQ-008 ld_data  input  LOAD_W  table bits, LSB first.
REQ-009 ld_last  input  1  marks the final load beat.
REQ-010 busy / done / err  output  1 each  load status.
REQ-011 in_valid  input  1  lookup request.
REQ-012 in_addr  input  NEURONS*IN_BITS  per-neuron address; neuron n uses slice [n*IN_BITS +: IN_BITS].
REQ-013 out_valid / out_bits  output  1 / NEURONS  lookup result; bit n is neuron n.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, ERR.
REQ-015 IDLE->LOAD on start; LOAD->RUN on an accepted beat with ld_last on the final beat count; LOAD->ERR on ld_last before the final beat, or on the final beat without ld_last.
REQ-016 ld_ready SHALL be 1 only in LOAD; a beat is accepted when ld_valid && ld_ready.
REQ-017 Bit stream order: neuron 0 entry 0 first, entry-major within a neuron, then neuron 1, and so on; bit k of the stream is written to neuron k/2**IN_BITS, entry k%2**IN_BITS.
REQ-018 Beat counter counts 0..NEURONS*2**IN_BITS/LOAD_W-1 and never wraps; it clears on entering LOAD.
REQ-019 start in LOAD SHALL be ignored; start in RUN or ERR SHALL re-enter LOAD, and the tables SHALL be overwritten.
REQ-020 busy = (state==LOAD); done = (state==RUN); err = (state==ERR).
REQ-021 Lookups are served only in RUN: out_valid is registered in_valid&&RUN with 1-cycle latency, and out_bits is the registered table read.
REQ-022 Outside RUN, out_valid SHALL be 0 and out_bits SHALL hold its last value.
REQ-023 A lookup and re-entry into LOAD in the same cycle: the lookup SHALL complete using the old tables.

Reset
REQ-024 rst SHALL force IDLE, beat counter 0, ld_ready 0, busy/done/err 0, out_valid 0, and out_bits 0.
REQ-025 Table contents are not reset; after a reset during LOAD, a fresh load is required before any lookup is served.

Configuration
REQ-026 With macro LUT_TABLE_READBACK_EN defined, ports rb_req (in, 1), rb_sel (in, clog2(NEURONS)), rb_addr (in, IN_BITS), and rb_data (out, 1) exist; rb_data SHALL return the addressed table bit 1 cycle after rb_req, in any state except LOAD.
REQ-027 In LOAD, rb_data SHALL be 0; without the macro, these ports and their logic are absent.

Structure
REQ-028 Shared package lut_pkg holds the state enum, the default-parameter localparams, and the beats-per-load function.
REQ-029 One sub-module, lut_table_ram, SHALL implement a single neuron's 2**IN_BITS x 1 distributed RAM with 1 write port and a registered read; it is instantiated NEURONS times.

Verification
REQ-030 Load a pattern equal to the 64-entry table where out=1 iff addr[4]==1 && addr[5]==0, for all 8 neurons (64 beats, ld_last on beat 63), then look up 0x10 and 0x30 -> out_bits 0xFF then 0x00 one cycle after each request, and done=1.
REQ-031 Assert ld_last on beat 10 -> err=1 and ld_ready=0 next cycle; a subsequent in_valid -> out_valid stays 0.
REQ-032 Hold ld_valid toggling randomly with backpressure-free stalls during a load -> tables match the stream order bit-exact across all 512 bits.
REQ-033 Assert rst at beat 30, then issue start and a full load -> done=1 and results correct; before the reload, lookups produce no out_valid.
REQ-034 In RUN, pulse start with in_valid in the same cycle -> one out_valid using the old table, then busy=1.
REQ-035 With LUT_TABLE_READBACK_EN, after a load read rb_sel=3, rb_addr=0x10 -> rb_data=1 in the next cycle; with rb_req during LOAD -> rb_data=0.
